// File: rtl/pe_writeback_pkg.sv
// Shared constants and types for the butterfly write-back block.
package pe_writeback_pkg;

  // Default geometry of one NTT/INTT stage
  localparam int DATA_W    = 14;
  localparam int ADDR_W    = 8;
  localparam int NUM_PAIRS = 256;
  localparam int LAT_NTT   = 9;
  localparam int LAT_INTT  = 7;

  // Stage controller states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Larger of two integers, used to size the delay line
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pe_writeback_tag_delay_line.sv
// Shift register carrying {valid, addr_upper, addr_lower} alongside the
// butterfly pipeline. The tap position follows the latched mode so the
// addresses emerge exactly when the matching butterfly results do.
module tag_delay_line #(
  parameter int ADDR_W   = 8,
  parameter int LAT_NTT  = 9,
  parameter int LAT_INTT = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              mode,
  input  logic              push_valid,
  input  logic [ADDR_W-1:0] push_upper,
  input  logic [ADDR_W-1:0] push_lower,
  output logic              tap_valid,
  output logic [ADDR_W-1:0] tap_upper,
  output logic [ADDR_W-1:0] tap_lower
);
  import pe_writeback_pkg::*;

  // Stage k holds an entry pushed k+1 edges ago, so the tap at index LAT
  // lines up with the register stage that follows the butterfly output.
  localparam int DEPTH = max_int(LAT_NTT, LAT_INTT) + 1;

  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [ADDR_W-1:0] upper_q [DEPTH];
  logic [ADDR_W-1:0] upper_d [DEPTH];
  logic [ADDR_W-1:0] lower_q [DEPTH];
  logic [ADDR_W-1:0] lower_d [DEPTH];

  // Shift one stage per cycle; a flush drops every in-flight tag
  always_comb begin
    valid_d    = {valid_q[DEPTH-2:0], push_valid};
    upper_d[0] = push_upper;
    lower_d[0] = push_lower;
    for (int i = 1; i < DEPTH; i++) begin
      upper_d[i] = upper_q[i-1];
      lower_d[i] = lower_q[i-1];
    end
    if (flush) valid_d = '0;
  end

  // Delay-line registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        upper_q[i] <= '0;
        lower_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      upper_q <= upper_d;
      lower_q <= lower_d;
    end
  end

  // Mode-selected tap
  always_comb begin
    if (mode) begin
      tap_valid = valid_q[LAT_INTT];
      tap_upper = upper_q[LAT_INTT];
      tap_lower = lower_q[LAT_INTT];
    end else begin
      tap_valid = valid_q[LAT_NTT];
      tap_upper = upper_q[LAT_NTT];
      tap_lower = lower_q[LAT_NTT];
    end
  end

endmodule

// File: rtl/pe_writeback.sv
// Write-back controller for one NTT/INTT stage: tracks issued butterfly
// pairs, re-times their read addresses to match the butterfly latency and
// writes the results back to both banks.
module pe_writeback #(
  parameter int DATA_W    = pe_writeback_pkg::DATA_W,
  parameter int ADDR_W    = pe_writeback_pkg::ADDR_W,
  parameter int NUM_PAIRS = pe_writeback_pkg::NUM_PAIRS,
  parameter int LAT_NTT   = pe_writeback_pkg::LAT_NTT,
  parameter int LAT_INTT  = pe_writeback_pkg::LAT_INTT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              sel_ntt,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_addr_upper,
  input  logic [ADDR_W-1:0] issue_addr_lower,
  input  logic [DATA_W-1:0] bf_upper,
  input  logic [DATA_W-1:0] bf_lower,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr_upper,
  output logic [ADDR_W-1:0] wr_addr_lower,
  output logic [DATA_W-1:0] wr_data_upper,
  output logic [DATA_W-1:0] wr_data_lower,
  output logic              busy,
  output logic              done,
  output logic              err
);
  import pe_writeback_pkg::*;

  localparam int               CNT_W    = $clog2(NUM_PAIRS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(NUM_PAIRS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_PAIRS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e            state_q, state_d;
  logic              mode_q, mode_d;
  logic [CNT_W-1:0]  issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic              err_q, err_d;
  logic              wr_en_q, wr_en_d;
  logic              done_q, done_d;
  logic [ADDR_W-1:0] wr_addr_upper_q, wr_addr_upper_d;
  logic [ADDR_W-1:0] wr_addr_lower_q, wr_addr_lower_d;
  logic [DATA_W-1:0] wr_data_upper_q, wr_data_upper_d;
  logic [DATA_W-1:0] wr_data_lower_q, wr_data_lower_d;

  logic              start_acc, issue_acc, proto_err;
  logic              tap_valid;
  logic [ADDR_W-1:0] tap_upper, tap_lower;

  // Only IDLE accepts a start and only RUN accepts issues; anything else
  // is a protocol violation that is flagged but otherwise ignored.
  assign start_acc = start && (state_q == ST_IDLE);
  assign issue_acc = issue_valid && (state_q == ST_RUN);
  assign proto_err = (start && (state_q != ST_IDLE)) ||
                     (issue_valid && (state_q != ST_RUN));

  tag_delay_line #(
    .ADDR_W   (ADDR_W),
    .LAT_NTT  (LAT_NTT),
    .LAT_INTT (LAT_INTT)
  ) u_tag_delay_line (
    .clk        (clk),
    .rst        (rst),
    .flush      (start_acc),
    .mode       (mode_q),
    .push_valid (issue_acc),
    .push_upper (issue_addr_upper),
    .push_lower (issue_addr_lower),
    .tap_valid  (tap_valid),
    .tap_upper  (tap_upper),
    .tap_lower  (tap_lower)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // FSM next state: the final issue and the final write each end their phase
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_RUN;
      ST_RUN:   if (issue_acc && (issue_cnt_q == CNT_LAST)) state_d = ST_DRAIN;
      ST_DRAIN: if (wr_cnt_q == CNT_MAX) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state_q != ST_IDLE);
  end

  // Counters, mode latch, error flag and write-port next values
  always_comb begin
    mode_d          = mode_q;
    issue_cnt_d     = issue_cnt_q;
    wr_cnt_d        = wr_cnt_q;
    err_d           = err_q;
    wr_en_d         = tap_valid;
    done_d          = 1'b0;
    wr_addr_upper_d = wr_addr_upper_q;
    wr_addr_lower_d = wr_addr_lower_q;
    wr_data_upper_d = wr_data_upper_q;
    wr_data_lower_d = wr_data_lower_q;

    if (start_acc) begin
      mode_d      = sel_ntt;
      issue_cnt_d = '0;
      wr_cnt_d    = '0;
      err_d       = 1'b0;
    end

    if (issue_acc && (issue_cnt_q != CNT_MAX)) issue_cnt_d = issue_cnt_q + CNT_ONE;

    // Address and data are captured together so they land in one write
    if (tap_valid) begin
      wr_addr_upper_d = tap_upper;
      wr_addr_lower_d = tap_lower;
      wr_data_upper_d = bf_upper;
      wr_data_lower_d = bf_lower;
      if (wr_cnt_q != CNT_MAX) wr_cnt_d = wr_cnt_q + CNT_ONE;
      if (wr_cnt_q == CNT_LAST) done_d = 1'b1;
    end

    if (proto_err) err_d = 1'b1;
  end

  // Datapath and control registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q          <= 1'b0;
      issue_cnt_q     <= '0;
      wr_cnt_q        <= '0;
      err_q           <= 1'b0;
      wr_en_q         <= 1'b0;
      done_q          <= 1'b0;
      wr_addr_upper_q <= '0;
      wr_addr_lower_q <= '0;
      wr_data_upper_q <= '0;
      wr_data_lower_q <= '0;
    end else begin
      mode_q          <= mode_d;
      issue_cnt_q     <= issue_cnt_d;
      wr_cnt_q        <= wr_cnt_d;
      err_q           <= err_d;
      wr_en_q         <= wr_en_d;
      done_q          <= done_d;
      wr_addr_upper_q <= wr_addr_upper_d;
      wr_addr_lower_q <= wr_addr_lower_d;
      wr_data_upper_q <= wr_data_upper_d;
      wr_data_lower_q <= wr_data_lower_d;
    end
  end

  assign wr_en         = wr_en_q;
  assign done          = done_q;
  assign err           = err_q;
  assign wr_addr_upper = wr_addr_upper_q;
  assign wr_addr_lower = wr_addr_lower_q;
  assign wr_data_upper = wr_data_upper_q;
  assign wr_data_lower = wr_data_lower_q;

endmodule

// File: tb/tb_pe_writeback.sv
// Self-checking bench for pe_writeback: a per-stage scenario table plus
// hand-written protocol-error and reset sequences, with every write
// checked against a scoreboard of expected {cycle, addresses, data, done}.
module tb_pe_writeback;

  localparam int DW    = 14;
  localparam int AW    = 8;
  localparam int NP    = 256;
  localparam int L_NTT = 9;
  localparam int L_INT = 7;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          sel_ntt = 1'b0;
  logic          issue_valid = 1'b0;
  logic [AW-1:0] issue_addr_upper = '0;
  logic [AW-1:0] issue_addr_lower = '0;
  logic [DW-1:0] bf_upper = '0;
  logic [DW-1:0] bf_lower = '0;
  logic          wr_en;
  logic [AW-1:0] wr_addr_upper, wr_addr_lower;
  logic [DW-1:0] wr_data_upper, wr_data_lower;
  logic          busy, done, err;

  pe_writeback dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .sel_ntt          (sel_ntt),
    .issue_valid      (issue_valid),
    .issue_addr_upper (issue_addr_upper),
    .issue_addr_lower (issue_addr_lower),
    .bf_upper         (bf_upper),
    .bf_lower         (bf_lower),
    .wr_en            (wr_en),
    .wr_addr_upper    (wr_addr_upper),
    .wr_addr_lower    (wr_addr_lower),
    .wr_data_upper    (wr_data_upper),
    .wr_data_lower    (wr_data_lower),
    .busy             (busy),
    .done             (done),
    .err              (err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int stage_writes = 0;

  typedef struct {
    int          cyc;
    logic [AW-1:0] au;
    logic [AW-1:0] al;
    logic        last;
  } exp_t;
  exp_t exp_q[$];

  logic [AW-1:0] last_au = '0, last_al = '0;
  logic [DW-1:0] last_du = '0, last_dl = '0;

  function automatic logic [DW-1:0] hash_u(input int c);
    return DW'(c * 37 + 11);
  endfunction
  function automatic logic [DW-1:0] hash_l(input int c);
    return DW'(c * 101 + 7);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Butterfly results change every cycle so each write's data is traceable
  always @(posedge clk) begin
    #1;
    bf_upper = hash_u(cyc);
    bf_lower = hash_l(cyc);
  end

  // Write-port monitor: every wr_en must match the next scoreboard entry,
  // and idle cycles must hold the previous write values with done low
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      stage_writes++;
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 32'(wr_addr_upper), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("wr_cycle", 32'(cyc), 32'(e.cyc));
        chk("wr_addr_upper", 32'(wr_addr_upper), 32'(e.au));
        chk("wr_addr_lower", 32'(wr_addr_lower), 32'(e.al));
        chk("wr_data_upper", 32'(wr_data_upper), 32'(hash_u(cyc - 1)));
        chk("wr_data_lower", 32'(wr_data_lower), 32'(hash_l(cyc - 1)));
        chk("done_on_write", 32'(done), 32'(e.last));
        last_au = e.au;
        last_al = e.al;
        last_du = hash_u(cyc - 1);
        last_dl = hash_l(cyc - 1);
      end
    end else begin
      chk("done_idle", 32'(done), 32'(0));
      chk("hold_addr", {8'h0, wr_addr_upper, 8'h0, wr_addr_lower}, {8'h0, last_au, 8'h0, last_al});
      chk("hold_data", {2'b0, wr_data_upper, 2'b0, wr_data_lower}, {2'b0, last_du, 2'b0, last_dl});
    end
  end

  // One full stage: start, NUM_PAIRS issues with optional gaps, sel_ntt
  // toggling and an illegal start injected mid-run, then drain checks
  task automatic run_stage(input logic mode, input int gap, input logic toggle,
                           input int inject, input logic exp_err);
    int lat;
    int n;
    lat = mode ? L_INT : L_NTT;
    stage_writes = 0;
    start = 1'b1;
    sel_ntt = mode;
    step();
    start = 1'b0;
    chk("start_busy", 32'(busy), 32'(1));
    chk("start_err_clear", 32'(err), 32'(0));
    for (int i = 0; i < NP; i++) begin
      issue_valid = 1'b1;
      issue_addr_upper = AW'(i);
      issue_addr_lower = AW'(i + 128);
      if (toggle) sel_ntt = ~sel_ntt;
      start = (i == inject);
      exp_q.push_back('{cyc: cyc + lat + 2, au: AW'(i), al: AW'(i + 128), last: (i == NP - 1)});
      step();
      issue_valid = 1'b0;
      start = 1'b0;
      for (int g = 0; g < gap; g++) step();
    end
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      step();
      n++;
    end
    chk("drain_complete", 32'(exp_q.size()), 32'(0));
    exp_q.delete();
    chk("writes_per_stage", 32'(stage_writes), 32'(NP));
    chk("end_busy", 32'(busy), 32'(0));
    chk("end_err", 32'(err), 32'(exp_err));
  endtask

  typedef struct {
    logic mode;
    int   gap;
    logic toggle;
    int   inject;
    logic exp_err;
    logic b2b;
  } stage_vec_t;

  stage_vec_t vecs[5];

  initial begin
    vecs[0] = '{mode: 1'b0, gap: 0, toggle: 1'b0, inject: -1, exp_err: 1'b0, b2b: 1'b0};
    vecs[1] = '{mode: 1'b1, gap: 1, toggle: 1'b0, inject: -1, exp_err: 1'b0, b2b: 1'b0};
    vecs[2] = '{mode: 1'b0, gap: 0, toggle: 1'b1, inject: -1, exp_err: 1'b0, b2b: 1'b1};
    vecs[3] = '{mode: 1'b1, gap: 0, toggle: 1'b1, inject: 40, exp_err: 1'b1, b2b: 1'b1};
    vecs[4] = '{mode: 1'b0, gap: 2, toggle: 1'b0, inject: -1, exp_err: 1'b0, b2b: 1'b0};

    // Reset state
    #3 rst = 1'b0;
    #1;
    chk("reset_wr_en", 32'(wr_en), 32'(0));
    chk("reset_busy", 32'(busy), 32'(0));
    chk("reset_done", 32'(done), 32'(0));
    chk("reset_err", 32'(err), 32'(0));
    chk("reset_addr", {24'h0, wr_addr_upper | wr_addr_lower}, 32'(0));
    step();
    step();
    rst = 1'b1;
    step();

    // Issue while idle: flagged, otherwise ignored
    issue_valid = 1'b1;
    issue_addr_upper = 8'h55;
    issue_addr_lower = 8'hAA;
    step();
    issue_valid = 1'b0;
    chk("idle_issue_err", 32'(err), 32'(1));
    chk("idle_issue_busy", 32'(busy), 32'(0));
    for (int k = 0; k < 15; k++) step();

    // Stage scenario table
    for (int v = 0; v < 5; v++) begin
      if (!vecs[v].b2b) begin
        step();
        step();
        step();
      end
      run_stage(vecs[v].mode, vecs[v].gap, vecs[v].toggle, vecs[v].inject, vecs[v].exp_err);
    end

    // Reset mid-stage after 100 issues
    step();
    start = 1'b1;
    sel_ntt = 1'b0;
    step();
    start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      issue_valid = 1'b1;
      issue_addr_upper = AW'(i);
      issue_addr_lower = AW'(i + 128);
      exp_q.push_back('{cyc: cyc + L_NTT + 2, au: AW'(i), al: AW'(i + 128), last: 1'b0});
      step();
    end
    issue_valid = 1'b0;
    rst = 1'b0;
    exp_q.delete();
    last_au = '0;
    last_al = '0;
    last_du = '0;
    last_dl = '0;
    #1;
    chk("midrst_wr_en", 32'(wr_en), 32'(0));
    chk("midrst_busy", 32'(busy), 32'(0));
    chk("midrst_addr", {16'h0, wr_addr_upper, wr_addr_lower}, 32'(0));
    chk("midrst_data", {4'h0, wr_data_upper, wr_data_lower}, 32'(0));
    chk("midrst_done_err", {30'h0, done, err}, 32'(0));
    step();
    step();
    step();
    rst = 1'b1;
    for (int k = 0; k < 20; k++) step();
    chk("post_rst_busy", 32'(busy), 32'(0));
    run_stage(1'b1, 0, 1'b0, -1, 1'b0);

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pe_writeback.md
PE_WRITEBACK -- requirements
Module: pe_writeback

Interface
REQ-001 SHALL have parameter DATA_W, default 14, coefficient width.
REQ-002 SHALL have parameter ADDR_W, default 8, per-bank address width.
REQ-003 SHALL have parameter NUM_PAIRS, default 256, butterfly pairs per stage.
REQ-004 SHALL have parameter LAT_NTT, default 9, butterfly-unit latency from inputs to outputs for forward NTT (sel_ntt=0).
REQ-005 SHALL have parameter LAT_INTT, default 7, butterfly-unit latency from inputs to outputs for inverse NTT (sel_ntt=1).
REQ-006 clk  input  1  single clock; all state on rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-low.
REQ-008 start  input  1  one-cycle stage start pulse.
REQ-009 sel_ntt  input  1  mode (0 NTT, 1 INTT), sampled only on accepted start.
REQ-010 issue_valid  input  1  a pair entered the butterfly unit this cycle.
REQ-011 issue_addr_upper, issue_addr_lower  input  ADDR_W each  read addresses of the issued pair.
REQ-012 bf_upper, bf_lower  input  DATA_W each  butterfly results.
REQ-013 wr_en  output  1  write strobe to both banks.
REQ-014 wr_addr_upper, wr_addr_lower  output  ADDR_W each  write addresses.
REQ-015 wr_data_upper, wr_data_lower  output  DATA_W each  write data.
REQ-016 busy  output  1  high in RUN or DRAIN.
REQ-017 done  output  1  one-cycle pulse at stage completion.
REQ-018 err  output  1  sticky protocol-error flag, cleared on accepted start.

Function
REQ-019 FSM states IDLE, RUN, DRAIN. IDLE->RUN on start. RUN->DRAIN when issue count reaches NUM_PAIRS. DRAIN->IDLE when write count reaches NUM_PAIRS.
REQ-020 On accepted start: latch sel_ntt as mode, clear issue and write counters, clear err, flush the delay line.
REQ-021 start outside IDLE is ignored and sets err.
REQ-022 issue_valid in RUN pushes {issue_addr_upper, issue_addr_lower} into the delay line and increments the issue counter.
REQ-023 issue_valid in IDLE or DRAIN is ignored and sets err.
REQ-024 The delay-line tap equals LAT_NTT when mode=0 and LAT_INTT when mode=1.
REQ-025 Valid tag delay equals address delay exactly.
REQ-026 When a tag emerges, wr_en, both addresses and bf_upper/bf_lower are registered together.
REQ-027 Issue at edge t yields wr_en high during the cycle after edge t+LAT+1.
REQ-028 wr_en lasts exactly one cycle per issued pair.
REQ-029 Back-to-back issues produce back-to-back writes with no bubbles or reordering.
REQ-030 In the cycle wr_en is low, wr_addr and wr_data hold their previous values.
REQ-031 The write counter increments on each wr_en.
REQ-032 done pulses in the same cycle as the NUM_PAIRS-th wr_en.
REQ-033 The FSM returns to IDLE on the edge after done; busy deasserts that cycle.
REQ-034 A new start in the cycle after done is accepted.
REQ-035 Counters are ceil(log2(NUM_PAIRS+1)) bits wide and do not wrap.
REQ-036 The final issue in RUN transitions to DRAIN on the same edge.
REQ-037 Delay-line depth is max(LAT_NTT, LAT_INTT) + 1.

Reset
REQ-038 rst low asynchronously clears all outputs to 0, the FSM to IDLE, the counters and mode to 0, and all delay-line valid tags to 0.
REQ-039 Reset mid-stage discards every in-flight pair; no wr_en is issued after reset release until new issues arrive.

Structure
REQ-040 A shared package holds DATA_W, ADDR_W, NUM_PAIRS, LAT_NTT, LAT_INTT and the FSM state enumeration.
REQ-041 One sub-module, tag_delay_line, holds the {valid, addr_upper, addr_lower} shift register with a mode-selected tap; the top holds the FSM, counters and output registers.

Verification
REQ-042 NTT burst: start, sel_ntt=0, 256 consecutive issues with addr_upper=i, addr_lower=i+128 -> 256 consecutive wr_en starting 10 cycles after the first issue, addresses in order, done on the 256th write, err=0.
REQ-043 INTT gapped: sel_ntt=1, issues on alternate cycles -> wr_en 8 cycles after each issue, gaps preserved, data equal to bf_* sampled one cycle before each wr_en.
REQ-044 Mode latch: sel_ntt toggled during RUN -> latency stays at the value selected at start.
REQ-045 Protocol errors: issue_valid in IDLE, then start during RUN -> err set, FSM and counters unaffected; next accepted start clears err.
REQ-046 Reset mid-stage: rst low after 100 issues, held 3 cycles -> outputs 0, IDLE, and no wr_en until a new start and new issues arrive.
REQ-047 Back-to-back stages: start in the cycle after done -> accepted, and the second stage completes with exactly 256 writes.
